// File: rtl/gen_uart_rx_fifo.sv
// UART receive buffer: drains the receiver holding register into a FWFT FIFO of
// {pe, fe, data} entries with level/timeout interrupts and a sticky overflow flag.
module gen_uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 640
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [7:0]            rx_data,
    input  logic                  rx_full,
    input  logic                  rx_fe,
    input  logic                  rx_pe,
    input  logic                  rx_ovr,
    output logic                  rx_ack,
    input  logic                  rd,
    output logic [7:0]            dout,
    output logic                  dout_fe,
    output logic                  dout_pe,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    input  logic [DEPTH_LOG2:0]   level,
    input  logic                  ie,
    input  logic                  clr,
    output logic                  ovf,
    output logic                  tmo,
    output logic                  irq_n
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]         TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } capState_e;

    capState_e             state_q, state_d;
    logic                  rxAck_q, rxAck_d;
    logic [9:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;
    logic                  irqN_q, irqN_d;
    logic [15:0]           tmoCnt_q, tmoCnt_d;

    logic                  isEmpty, isFull, capture, popAcc, hasSpace, push, pop;
    logic [9:0]            headEntry;

    always_comb begin
        isEmpty  = (count_q == '0);
        isFull   = (count_q == DEPTH_CNT);
        capture  = (state_q == IDLE) && rx_full;
        popAcc   = rd && !isEmpty;
        // A pop in the same cycle frees the slot the incoming byte needs.
        hasSpace = !isFull || popAcc;
        push     = capture && hasSpace && !clr;
        pop      = popAcc && !clr;
    end

    always_comb begin
        state_d = state_q;
        rxAck_d = 1'b0;
        if (state_q == IDLE) begin
            if (rx_full) begin
                rxAck_d = 1'b1;
                state_d = WAIT;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        tmoCnt_d = tmoCnt_q;
        if (clr) begin
            wrPtr_d  = '0;
            rdPtr_d  = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            tmo_d    = 1'b0;
            tmoCnt_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + 1'b1;
            if (pop)  rdPtr_d = rdPtr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (capture && (!hasSpace || rx_ovr)) ovf_d = 1'b1;
            // The idle counter parks at its last value once the timeout fires.
            if (isEmpty || push || pop) begin
                tmoCnt_d = '0;
            end else if (tick) begin
                if (tmoCnt_q == TMO_LAST) tmo_d = 1'b1;
                else                      tmoCnt_d = tmoCnt_q + 16'd1;
            end
            if (pop) tmo_d = 1'b0;
        end
        irqN_d = ~(ie & (((level != '0) && (count_q >= level)) | tmo_q | ovf_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rxAck_q  <= 1'b0;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            irqN_q   <= 1'b1;
            tmoCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rxAck_q  <= rxAck_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            irqN_q   <= irqN_d;
            tmoCnt_q <= tmoCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= {rx_pe, rx_fe, rx_data};
    end

    always_comb begin
        headEntry = isEmpty ? 10'h000 : mem_q[rdPtr_q];
        dout      = headEntry[7:0];
        dout_fe   = headEntry[8];
        dout_pe   = headEntry[9];
        empty     = isEmpty;
        count     = count_q;
        rx_ack    = rxAck_q;
        ovf       = ovf_q;
        tmo       = tmo_q;
        irq_n     = irqN_q;
    end

endmodule
